// File: rtl/obstacle_spawner_if.sv
// Obstacle bus between the spawner and the collision checker: position/lane forward, despawn back.
interface obstacle_spawner_if #(
    parameter int LWIDTH = 2,
    parameter int HWIDTH = 12,
    parameter int VWIDTH = 12
);
    logic [LWIDTH-1:0]        obst_lane;
    logic signed [HWIDTH-1:0] obst_hoffset;
    logic signed [VWIDTH-1:0] obst_voffset;
    logic                     obst_active;
    logic                     despawn;

    modport master (
        output obst_lane, obst_hoffset, obst_voffset, obst_active,
        input  despawn
    );

    modport slave (
        input  obst_lane, obst_hoffset, obst_voffset, obst_active,
        output despawn
    );
endinterface

// File: rtl/obstacle_spawner.sv
// Single-obstacle spawner: LFSR lane/gap pick, tick-driven descent, dodge/hit counters; all outputs registered.
// Optional OBSTACLE_SPEEDUP_EN: step grows by 1 every SPEEDUP_EVERY dodges, capped at MAX_STEP.
module obstacle_spawner #(
    parameter int          HWIDTH      = 12,
    parameter int          VWIDTH      = 12,
    parameter int          LWIDTH      = 2,
    parameter int          NUM_LANES   = 3,
    parameter int          COUNT_WIDTH = 32,
    parameter int          TICK_DIV    = 833333,
    parameter int          SPAWN_V     = -240,
    parameter int          END_V       = 240,
    parameter int          STEP        = 4,
    parameter int          LANE_X0     = -160,
    parameter int          LANE_PITCH  = 160,
    parameter int          MIN_GAP     = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
`ifdef OBSTACLE_SPEEDUP_EN
    ,
    parameter int          SPEEDUP_EVERY = 8,
    parameter int          MAX_STEP      = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    obstacle_spawner_if.master     bus,
    output logic [COUNT_WIDTH-1:0] dodged,
    output logic [COUNT_WIDTH-1:0] hits
);

    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 16);
    localparam logic [15:0]               LFSR_MASK = 16'hB400;
    localparam logic signed [VWIDTH:0]    STEP_X    = STEP[VWIDTH:0];
    localparam logic signed [VWIDTH:0]    END_X     = END_V[VWIDTH:0];
    localparam logic signed [VWIDTH-1:0]  SPAWN_X   = SPAWN_V[VWIDTH-1:0];

    typedef enum logic [1:0] {IDLE, WAIT, SPAWN, ACTIVE} state_t;

    state_t                   state;
    logic [15:0]              lfsr;
    logic [15:0]              lfsr_next;
    logic [DIV_W-1:0]         div;
    logic                     tick;
    logic [GAP_W-1:0]         gap;
    logic [GAP_W-1:0]         gap_load;
    logic [LWIDTH-1:0]        lane_raw;
    logic [LWIDTH-1:0]        lane_pick;
    logic signed [HWIDTH-1:0] hoff_pick;
    logic signed [VWIDTH:0]   v_next;
    logic signed [VWIDTH:0]   step_x;

`ifdef OBSTACLE_SPEEDUP_EN
    localparam int SPD_W = $clog2(SPEEDUP_EVERY + 1);
    localparam logic signed [VWIDTH:0] MAX_X = MAX_STEP[VWIDTH:0];
    logic signed [VWIDTH:0] step_q;
    logic [SPD_W-1:0]       spd_cnt;
    assign step_x = step_q;
`else
    assign step_x = STEP_X;
`endif

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        tick      = enable && (div == DIV_W'(TICK_DIV - 1));
        gap_load  = GAP_W'(MIN_GAP) + GAP_W'(lfsr[3:0]);
        lane_raw  = lfsr[LWIDTH-1:0];
        // Out-of-range raw values fold back into the legal lane set.
        lane_pick = (int'(lane_raw) < NUM_LANES) ? lane_raw : lane_raw - LWIDTH'(NUM_LANES);
        hoff_pick = HWIDTH'(LANE_X0 + int'(lane_pick) * LANE_PITCH);
        // One extra bit so a step past the top of the range cannot wrap negative.
        v_next    = {bus.obst_voffset[VWIDTH-1], bus.obst_voffset} + step_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lfsr             <= LFSR_SEED;
            div              <= '0;
            gap              <= '0;
            bus.obst_lane    <= '0;
            bus.obst_hoffset <= HWIDTH'(LANE_X0);
            bus.obst_voffset <= SPAWN_X;
            bus.obst_active  <= 1'b0;
            dodged           <= '0;
            hits             <= '0;
`ifdef OBSTACLE_SPEEDUP_EN
            step_q           <= STEP_X;
            spd_cnt          <= '0;
`endif
        end else if (enable) begin
            lfsr <= lfsr_next;
            div  <= tick ? '0 : div + 1'b1;
            case (state)
                IDLE: begin
                    gap   <= gap_load;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tick) begin
                        if (gap == '0) state <= SPAWN;
                        else           gap   <= gap - 1'b1;
                    end
                end
                SPAWN: begin
                    bus.obst_lane    <= lane_pick;
                    bus.obst_hoffset <= hoff_pick;
                    bus.obst_voffset <= SPAWN_X;
                    bus.obst_active  <= 1'b1;
                    state            <= ACTIVE;
                end
                ACTIVE: begin
                    // A hit takes priority over a pass on the same cycle.
                    if (bus.despawn) begin
                        hits             <= hits + 1'b1;
                        bus.obst_voffset <= SPAWN_X;
                        bus.obst_active  <= 1'b0;
                        gap              <= gap_load;
                        state            <= WAIT;
                    end else if (tick) begin
                        if (v_next >= END_X) begin
                            dodged           <= dodged + 1'b1;
                            bus.obst_voffset <= SPAWN_X;
                            bus.obst_active  <= 1'b0;
                            gap              <= gap_load;
                            state            <= WAIT;
`ifdef OBSTACLE_SPEEDUP_EN
                            if (spd_cnt == SPD_W'(SPEEDUP_EVERY - 1)) begin
                                spd_cnt <= '0;
                                if (step_q < MAX_X) step_q <= step_q + 1'b1;
                            end else begin
                                spd_cnt <= spd_cnt + 1'b1;
                            end
`endif
                        end else begin
                            bus.obst_voffset <= v_next[VWIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner with a one-cycle movement tick.
module tb_obstacle_spawner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] dodged;
    logic [31:0] hits;
    int          checks = 0;
    int          failures = 0;

`ifdef OBSTACLE_SPEEDUP_EN
    localparam int EXP_STEP = 5;
`else
    localparam int EXP_STEP = 4;
`endif

    obstacle_spawner_if #(.LWIDTH(2), .HWIDTH(12), .VWIDTH(12)) bus();

    obstacle_spawner #(.TICK_DIV(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus),
        .dodged (dodged),
        .hits   (hits)
    );

    always #5 clk = ~clk;

    task automatic wait_active(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.obst_active) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_voff(input int v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.obst_active && int'(bus.obst_voffset) == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.despawn = 1'b0;
        rst = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.obst_active !== 1'b0 || int'(bus.obst_voffset) != -240) begin
                failures++;
                $display("FAIL reset_pos: active=%0b voff=%0d required active=0 voff=-240",
                         bus.obst_active, bus.obst_voffset);
            end
            checks++;
            if (bus.obst_lane !== 2'd0 || int'(bus.obst_hoffset) != -160) begin
                failures++;
                $display("FAIL reset_lane: lane=%0d hoff=%0d required lane=0 hoff=-160",
                         bus.obst_lane, bus.obst_hoffset);
            end
            checks++;
            if (dodged !== 32'd0 || hits !== 32'd0) begin
                failures++;
                $display("FAIL reset_cnt: dodged=%0d hits=%0d required 0/0", dodged, hits);
            end
        end
    endtask

    task automatic test_dodge();
        int cnt;
        int low;
        cnt = 0;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.obst_active) break;
        end
        // IDLE->WAIT, gap 3 (seed low nibble 1) takes 4 ticks, then SPAWN: active after edge 6.
        checks++;
        if (cnt != 6) begin
            failures++;
            $display("FAIL first_spawn_latency: got %0d cycles required 6", cnt);
        end
        checks++;
        if (bus.obst_lane !== 2'd0 || int'(bus.obst_hoffset) != -160) begin
            failures++;
            $display("FAIL first_lane: lane=%0d hoff=%0d required lane=0 hoff=-160",
                     bus.obst_lane, bus.obst_hoffset);
        end
        for (int k = 0; k < 120; k++) begin
            checks++;
            if (int'(bus.obst_voffset) != -240 + 4 * k || bus.obst_active !== 1'b1) begin
                failures++;
                $display("FAIL descent step %0d: voff=%0d active=%0b required voff=%0d active=1",
                         k, bus.obst_voffset, bus.obst_active, -240 + 4 * k);
            end
            @(negedge clk);
        end
        checks++;
        if (dodged !== 32'd1 || bus.obst_active !== 1'b0 || int'(bus.obst_voffset) != -240) begin
            failures++;
            $display("FAIL dodge_retire: dodged=%0d active=%0b voff=%0d required 1/0/-240",
                     dodged, bus.obst_active, bus.obst_voffset);
        end
        // Gap g in [2,17] keeps active low for g+1 WAIT ticks plus the retire and SPAWN cycles minus one: g+2.
        low = 0;
        while (!bus.obst_active && low < 100) begin
            low++;
            @(negedge clk);
        end
        checks++;
        if (low < 4 || low > 19) begin
            failures++;
            $display("FAIL respawn_gap: low for %0d cycles required 4..19", low);
        end
    endtask

    task automatic test_hit();
        bit ok;
        wait_voff(0, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hit_wait: voff=0 not reached, voff=%0d", bus.obst_voffset);
        end
        bus.despawn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.obst_active !== 1'b0 || int'(bus.obst_voffset) != -240 || hits !== 32'd1) begin
            failures++;
            $display("FAIL hit_retire: active=%0b voff=%0d hits=%0d required 0/-240/1",
                     bus.obst_active, bus.obst_voffset, hits);
        end
        @(negedge clk);
        @(negedge clk);
        bus.despawn = 1'b0;
        @(negedge clk);
        checks++;
        if (hits !== 32'd1 || dodged !== 32'd1) begin
            failures++;
            $display("FAIL hit_once: hits=%0d dodged=%0d required 1/1", hits, dodged);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        wait_active(100, ok);
        wait_voff(236, 300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL simul_wait: voff=236 not reached, voff=%0d", bus.obst_voffset);
        end
        bus.despawn = 1'b1;
        @(negedge clk);
        bus.despawn = 1'b0;
        checks++;
        if (hits !== 32'd2 || dodged !== 32'd1 || bus.obst_active !== 1'b0) begin
            failures++;
            $display("FAIL simul_priority: hits=%0d dodged=%0d active=%0b required 2/1/0",
                     hits, dodged, bus.obst_active);
        end
    endtask

    task automatic test_pause();
        bit          ok;
        int          v_snap;
        logic [1:0]  l_snap;
        logic [31:0] d_snap;
        logic [31:0] h_snap;
        wait_active(100, ok);
        wait_voff(-200, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL pause_wait: voff=-200 not reached, voff=%0d", bus.obst_voffset);
        end
        enable = 1'b0;
        v_snap = int'(bus.obst_voffset);
        l_snap = bus.obst_lane;
        d_snap = dodged;
        h_snap = hits;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (int'(bus.obst_voffset) != -200 || bus.obst_lane !== l_snap ||
                dodged !== d_snap || hits !== h_snap || bus.obst_active !== 1'b1) begin
                failures++;
                $display("FAIL pause_frozen cycle %0d: voff=%0d lane=%0d dodged=%0d hits=%0d required %0d/%0d/%0d/%0d",
                         c, bus.obst_voffset, bus.obst_lane, dodged, hits, v_snap, l_snap, d_snap, h_snap);
            end
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (int'(bus.obst_voffset) != -196) begin
            failures++;
            $display("FAIL pause_resume: voff=%0d required -196", bus.obst_voffset);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.obst_active !== 1'b0 || int'(bus.obst_voffset) != -240 || bus.obst_lane !== 2'd0 ||
            int'(bus.obst_hoffset) != -160 || dodged !== 32'd0 || hits !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: active=%0b voff=%0d lane=%0d hoff=%0d dodged=%0d hits=%0d required reset values",
                     bus.obst_active, bus.obst_voffset, bus.obst_lane, bus.obst_hoffset, dodged, hits);
        end
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_speed();
        bit ok;
        int v0;
        for (int i = 0; i < 8; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (dodged == 32'(i + 1)) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL speed_dodge %0d: dodged=%0d required %0d", i, dodged, i + 1);
            end
        end
        wait_active(50, ok);
        v0 = int'(bus.obst_voffset);
        @(negedge clk);
        checks++;
        if (v0 != -240 || int'(bus.obst_voffset) - v0 != EXP_STEP) begin
            failures++;
            $display("FAIL step_after_8: v0=%0d v1=%0d required v0=-240 delta=%0d",
                     v0, bus.obst_voffset, EXP_STEP);
        end
    endtask

    task automatic test_lanes();
        bit ok;
        int h;
        int seen [3];
        seen = '{0, 0, 0};
        for (int n = 0; n < 1000; n++) begin
            wait_active(40, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL lane_spawn_timeout at spawn %0d", n);
                break;
            end
            h = int'(bus.obst_hoffset);
            checks++;
            if (bus.obst_lane > 2'd2) begin
                failures++;
                $display("FAIL lane_legal: lane=%0d required 0..2", bus.obst_lane);
            end else begin
                seen[bus.obst_lane]++;
            end
            checks++;
            if ((h != -160 && h != 0 && h != 160) || h != -160 + 160 * int'(bus.obst_lane)) begin
                failures++;
                $display("FAIL lane_hoffset: hoff=%0d lane=%0d required %0d",
                         h, bus.obst_lane, -160 + 160 * int'(bus.obst_lane));
            end
            bus.despawn = 1'b1;
            @(negedge clk);
            bus.despawn = 1'b0;
        end
        checks++;
        if (hits !== 32'd1000) begin
            failures++;
            $display("FAIL lane_hits: hits=%0d required 1000", hits);
        end
        checks++;
        if (seen[0] == 0 || seen[1] == 0 || seen[2] == 0) begin
            failures++;
            $display("FAIL lane_coverage: counts %0d/%0d/%0d required all nonzero", seen[0], seen[1], seen[2]);
        end
    endtask

    initial begin
        test_reset();
        test_dodge();
        test_hit();
        test_simultaneous();
        test_pause();
        test_mid_reset();
        test_speed();
        test_lanes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Producer end of the obstacle/collision interface: generates one obstacle at a time, picks its lane pseudo-randomly, and advances its vertical offset toward the player on a frame tick. It drives `obst_lane`, `obst_voffset` and `obst_hoffset` into the collision checker (lane array element 0), and consumes the checker's `despawn` pulse to retire a hit obstacle. It also counts obstacles that pass the player untouched ("dodged") for the score logic.

## Interface
Parameters:
- HWIDTH, 12: signed horizontal offset width.
- VWIDTH, 12: signed vertical offset width.
- LWIDTH, 2: lane index width.
- NUM_LANES, 3: legal lanes 0..NUM_LANES-1; must be ≤ 2^LWIDTH.
- COUNT_WIDTH, 32: dodged/hit counter width.
- TICK_DIV, 833333: clk cycles per movement tick; must be ≥ 1.
- SPAWN_V, -240: `obst_voffset` at spawn and while parked.
- END_V, 240: obstacle counts as passed once `obst_voffset` reaches or exceeds this value.
- STEP, 4: voffset increment per tick.
- LANE_X0, -160: hoffset of lane 0.
- LANE_PITCH, 160: hoffset spacing between lanes.
- MIN_GAP, 2: minimum ticks between retire and respawn; must be ≥ 2.
- LFSR_SEED, 16'hACE1: nonzero seed.
- SPEEDUP_EVERY, 8: dodges per speed step (macro only).
- MAX_STEP, 16: step ceiling (macro only).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  game running; low pauses the block.
- despawn  in  1  hit indication from the collision checker, level-sensitive.
- obst_lane  out  LWIDTH  current obstacle lane.
- obst_hoffset  out  HWIDTH signed  LANE_X0 + lane*LANE_PITCH.
- obst_voffset  out  VWIDTH signed  current vertical offset.
- obst_active  out  1  high while the obstacle is live (ACTIVE).
- dodged  out  COUNT_WIDTH  obstacles that reached END_V.
- hits  out  COUNT_WIDTH  obstacles retired by despawn.

## Operation
- 16-bit Galois LFSR, mask 16'hB400, loaded with LFSR_SEED on rst, advances every cycle `enable` is high.
- Lane pick: r = lfsr[LWIDTH-1:0]. Lane = r if r < NUM_LANES, else r − NUM_LANES.
- Gap load: MIN_GAP + lfsr[3:0] ticks.
- Tick: divider counts 0..TICK_DIV-1 while `enable` is high and pulses on wrap. `enable` low freezes the divider, FSM, counters and LFSR. All values are retained.
- FSM:
  - IDLE → WAIT on the first cycle `enable` is high; loads the gap.
  - WAIT: gap decrements on each tick. When the count is 0 on a tick → SPAWN.
  - SPAWN (one cycle): latch lane and hoffset; voffset = SPAWN_V; obst_active = 1; → ACTIVE.
  - ACTIVE, despawn = 1: hits += 1; voffset = SPAWN_V; obst_active = 0; load gap; → WAIT. This is evaluated every cycle, not only on ticks.
  - ACTIVE, tick, despawn = 0: compute v' = voffset + step in VWIDTH+1 bits, signed.
    - If v' ≥ END_V: dodged += 1; park as above; → WAIT.
    - Otherwise voffset = v'.
- Simultaneous despawn and pass on the same tick: despawn wins. hits increments, dodged does not.
- despawn outside ACTIVE is ignored. This covers the checker's registered despawn staying high for 1–2 cycles after retirement.
- Counters wrap modulo 2^COUNT_WIDTH.

## Timing
- Reset values:
  - state = IDLE, obst_active = 0
  - obst_voffset = SPAWN_V, obst_lane = 0, obst_hoffset = LANE_X0
  - dodged = 0, hits = 0, divider = 0, LFSR = LFSR_SEED
- All outputs are registered.
- despawn sampled high in ACTIVE → obst_active low and voffset = SPAWN_V on the next clk edge (1-cycle latency).
- A tick in ACTIVE → new voffset visible on the following edge.
- SPAWN lasts exactly one cycle. obst_active rises at the end of the SPAWN cycle.
- rst mid-operation: all state returns to reset values on that edge, regardless of `enable`.

## Configuration
- OBSTACLE_SPEEDUP_EN defined: step starts at STEP and increases by 1 each time dodged reaches a nonzero multiple of SPEEDUP_EVERY, saturating at MAX_STEP. rst returns step to STEP.
- OBSTACLE_SPEEDUP_EN undefined: step is the constant STEP; no speed logic is synthesized.

## Test plan
- Reset: TICK_DIV=1. Assert rst 2 cycles with enable=1. Outputs must equal the reset values, and state stays IDLE while rst is high.
- Dodge path: TICK_DIV=1, STEP=4, SPAWN_V=-240, END_V=240.
  - After spawn, voffset steps -240, -236, … up to 236.
  - The next tick retires the obstacle: dodged=1, obst_active=0, voffset=-240.
  - The respawn gap lies in [2,17] ticks.
- Hit path: despawn=1 for 3 cycles while voffset=0. Required: hits=1 exactly (not 3), obst_active=0 the next cycle, and dodged unchanged.
- Simultaneous: despawn=1 on the tick where v' ≥ END_V. Required: hits increments, dodged does not.
- Pause: drop enable for 10 cycles mid-ACTIVE. voffset, lane and counters must be frozen; motion resumes on the first tick after enable returns.
- Lane legality over 1000 spawns with NUM_LANES=3:
  - obst_lane is never 3.
  - obst_hoffset ∈ {-160, 0, 160}.
  - With OBSTACLE_SPEEDUP_EN defined: step = 5 after 8 dodges.
